// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: state enum,
// instruction width and PC increment.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_INC = 32'd4;

    localparam logic [1:0] ST_LOAD_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_FLUSH_ENC = 2'd2;

    typedef enum logic [1:0] {
        LOAD  = ST_LOAD_ENC,
        RUN   = ST_RUN_ENC,
        FLUSH = ST_FLUSH_ENC
    } fetch_state_e;

    function automatic logic [INSTR_W-1:0] pc_inc(input logic [INSTR_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Pair of saturating event counters; only exists when FETCH_CTRL_PERF_EN
// is defined.
`ifdef FETCH_CTRL_PERF_EN
module fetch_perf_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_a_i,
    input  logic         inc_b_i,
    output logic [W-1:0] cnt_a_o,
    output logic [W-1:0] cnt_b_o
);

    logic [W-1:0] a_q, a_d, b_q, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (inc_a_i && (a_q != '1)) a_d = a_q + W'(1);
        if (inc_b_i && (b_q != '1)) b_d = b_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign cnt_a_o = a_q;
    assign cnt_b_o = b_q;

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: loads the instruction image, then sequences
// the PC with redirect/stall/flush. FETCH_CTRL_PERF_EN adds stall/flush counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned        MEM_DEPTH_LOG2 = 8,
    parameter logic [INSTR_W-1:0] RESET_PC       = 32'h0
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      PCSrc,
    input  logic [INSTR_W-1:0]        InputAddress,
    input  logic                      stallDetector,
    input  logic                      LoadValid,
    input  logic [MEM_DEPTH_LOG2-1:0] LoadAddr,
    input  logic [INSTR_W-1:0]        LoadData,
    input  logic                      LoadDone,
    output logic                      LoadReady,
    output logic [INSTR_W-1:0]        PCAddress,
    output logic [MEM_DEPTH_LOG2-1:0] MemAddr,
    output logic                      MemWe,
    output logic [INSTR_W-1:0]        MemWdata,
    output logic                      FetchValid,
    output logic                      FlushIFID,
`ifdef FETCH_CTRL_PERF_EN
    output logic [15:0]               StallCount,
    output logic [15:0]               FlushCount,
`endif
    output logic                      AddrErr
);

    fetch_state_e              state_q, state_d;
    logic [INSTR_W-1:0]        pc_q, pc_d;
    logic                      we_q, we_d;
    logic [MEM_DEPTH_LOG2-1:0] waddr_q, waddr_d;
    logic [INSTR_W-1:0]        wdata_q, wdata_d;
    logic                      err_q;
    logic                      range_err;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            LOAD: begin
                if (LoadValid) begin
                    we_d    = 1'b1;
                    waddr_d = LoadAddr;
                    wdata_d = LoadData;
                end
                if (LoadDone) state_d = RUN;
            end
            RUN, FLUSH: begin
                state_d = RUN;
                if (PCSrc) begin
                    pc_d    = pc_inc(InputAddress);
                    state_d = FLUSH;
                end else if (stallDetector) begin
                    pc_d = pc_inc(pc_q);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= LOAD;
            pc_q    <= RESET_PC;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= AddrErr;
        end
    end

    assign range_err  = (state_q != LOAD) && (pc_q[INSTR_W-1:MEM_DEPTH_LOG2+2] != '0);
    assign AddrErr    = err_q | range_err;
    assign LoadReady  = (state_q == LOAD);
    assign FetchValid = (state_q == RUN);
    assign FlushIFID  = (state_q == FLUSH);
    assign PCAddress  = pc_q;
    assign MemWe      = we_q;
    assign MemWdata   = wdata_q;
    // The last image word lands in the first RUN cycle, so a pending write owns the address bus.
    assign MemAddr    = ((state_q == LOAD) || we_q) ? waddr_q : pc_q[MEM_DEPTH_LOG2+1:2];

`ifdef FETCH_CTRL_PERF_EN
    logic run_stall, redirect;

    assign run_stall = (state_q == RUN) && !PCSrc && !stallDetector;
    assign redirect  = (state_q != LOAD) && PCSrc;

    fetch_perf_cnt #(.W(16)) u_perf (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .inc_a_i (run_stall),
        .inc_b_i (redirect),
        .cnt_a_o (StallCount),
        .cnt_b_o (FlushCount)
    );
`endif

endmodule
